// File: rtl/fifo_burst_reader_pkg.sv
// fifo_pkg: shared widths, depth and burst FSM state type for the fifo read side
package fifo_pkg;
    localparam int FIFO_DW  = 8;
    localparam int FIFO_CW  = 5;
    localparam int MAX_DATA = 16;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} burst_state_t;
endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: fifo read port plus valid/ready output stream
// master: the burst reader (drives fifo_ren and the m_* beat, takes fifo status and m_ready)
// slave:  the fifo/consumer side (drives fifo status/data and m_ready)
interface fifo_burst_reader_if;
    logic [fifo_pkg::FIFO_CW-1:0] fifo_count;
    logic                         fifo_empty;
    logic [fifo_pkg::FIFO_DW-1:0] fifo_rdata;
    logic                         fifo_ren;
    logic                         m_valid;
    logic                         m_ready;
    logic [fifo_pkg::FIFO_DW-1:0] m_data;
    logic                         m_last;
    modport master (
        input  fifo_count, fifo_empty, fifo_rdata, m_ready,
        output fifo_ren, m_valid, m_data, m_last
    );
    modport slave (
        output fifo_count, fifo_empty, fifo_rdata, m_ready,
        input  fifo_ren, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader_timer.sv
// burst_timer: loadable beats-left down-counter, plus idle wait timer under FLUSH_TIMEOUT_EN
// clk, rst (async, active-high); load_i/load_val_i load the beat count; dec_i counts a read
// tmr_run_i (FLUSH_TIMEOUT_EN only) keeps the wait timer running, otherwise it clears
// beats_left_o count; done_o = last beat pending; timeout_o = wait timer expired
module burst_timer import fifo_pkg::*;
`ifdef FLUSH_TIMEOUT_EN
#(
    parameter int TIMEOUT = 8
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FIFO_CW-1:0] load_val_i,
    input  logic               dec_i,
`ifdef FLUSH_TIMEOUT_EN
    input  logic               tmr_run_i,
`endif
    output logic [FIFO_CW-1:0] beats_left_o,
    output logic               done_o,
    output logic               timeout_o
);
    logic [FIFO_CW-1:0] beats_q, beats_d;
    // the count saturates at zero rather than wrapping
    always_comb beats_d = load_i ? load_val_i : (dec_i && beats_q != '0) ? beats_q - 1'b1 : beats_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) beats_q <= '0;
        else     beats_q <= beats_d;
    end
    assign beats_left_o = beats_q;
    assign done_o       = beats_q == FIFO_CW'(1);
`ifdef FLUSH_TIMEOUT_EN
    logic [15:0] tmr_q, tmr_d;
    always_comb tmr_d = (tmr_run_i && !load_i) ? tmr_q + 16'd1 : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr_q <= '0;
        else     tmr_q <= tmr_d;
    end
    assign timeout_o = tmr_run_i && tmr_q == 16'(TIMEOUT - 1);
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a fifo in fixed-length bursts onto a valid/ready stream with m_last
// clk: rising-edge clock; rst: asynchronous active-high reset
// bus (master): fifo_count/fifo_empty/fifo_rdata in, fifo_ren out; m_valid/m_data/m_last out, m_ready in
// Option macro FLUSH_TIMEOUT_EN: flush residual data below BURST_LEN as a short burst after TIMEOUT idle cycles
module fifo_burst_reader #(
    parameter int MAX_DATA  = fifo_pkg::MAX_DATA,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 8
) (
    input logic                 clk,
    input logic                 rst,
    fifo_burst_reader_if.master bus
);
    import fifo_pkg::*;
    if (BURST_LEN < 1 || BURST_LEN > MAX_DATA || TIMEOUT < 1) begin : g_bad_params
        $error("fifo_burst_reader: illegal BURST_LEN/TIMEOUT");
    end
    burst_state_t       state_q;
    logic               m_valid_q, m_last_q;
    logic [FIFO_DW-1:0] m_data_q;
    logic [FIFO_CW-1:0] beats_left, load_val;
    logic               done, timeout, ren, xfer, full, load;
    always_comb begin
        xfer     = m_valid_q && bus.m_ready;
        // a read only happens when the output register is free or being emptied this cycle
        ren      = state_q == FETCH && beats_left != '0 && !bus.fifo_empty && (!m_valid_q || bus.m_ready);
        full     = bus.fifo_count >= FIFO_CW'(BURST_LEN);
        load     = state_q == IDLE && (full || timeout);
        load_val = full ? FIFO_CW'(BURST_LEN) : bus.fifo_count;
    end
    burst_timer
`ifdef FLUSH_TIMEOUT_EN
    #(.TIMEOUT(TIMEOUT))
`endif
    u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .load_val_i   (load_val),
        .dec_i        (ren),
`ifdef FLUSH_TIMEOUT_EN
        .tmr_run_i    (state_q == IDLE && !bus.fifo_empty && !full),
`endif
        .beats_left_o (beats_left),
        .done_o       (done),
        .timeout_o    (timeout)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= ren ? 1'b1 : xfer ? 1'b0 : m_valid_q;
            m_data_q  <= ren ? bus.fifo_rdata : m_data_q;
            m_last_q  <= ren ? done : m_last_q;
            state_q   <= (state_q == IDLE && load)              ? FETCH :
                         (state_q == FETCH && ren && done)      ? DRAIN :
                         (state_q == DRAIN && xfer && m_last_q) ? IDLE  : state_q;
        end
    end
    assign bus.fifo_ren = ren;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_last   = m_last_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: fifo model + scoreboard bench for fifo_burst_reader (BURST_LEN 4, TIMEOUT 8)
module tb_fifo_burst_reader;
    import fifo_pkg::*;
    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fifo_burst_reader_if bus();
    fifo_burst_reader dut (.clk(clk), .rst(rst), .bus(bus));
    logic [7:0] mem [16] = '{default: 8'h00};
    logic [3:0] wp = '0, rp = '0;
    logic [4:0] cnt = '0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       m_ready = 1'b0;
    assign bus.fifo_count = cnt;
    assign bus.fifo_empty = cnt == 5'd0;
    assign bus.fifo_rdata = mem[rp];
    assign bus.m_ready    = m_ready;
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp] <= wr_data;
            wp      <= wp + 4'd1;
        end
        if (bus.fifo_ren) rp <= rp + 4'd1;
        cnt <= cnt + 5'(wr_en) - 5'(bus.fifo_ren);
    end
    beat_t sb[$];
    beat_t mb;
    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    task automatic push(input logic [7:0] d, input logic l);
        sb.push_back('{d: d, l: l});
    endtask
    task automatic drain(input bit toggle);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            if (toggle) m_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        m_ready = 1'b1;
        check("drain_timeout", 32'(sb.size()), 32'd0);
        tick();
        tick();
        check("idle_after", 32'(dut.state_q), 32'(IDLE));
        check("cnt_after", 32'(cnt), 32'd0);
    endtask
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.m_valid), 32'd1);
                check("hold_beat", 32'({bus.m_last, bus.m_data}), 32'(prev_out));
            end
            if (bus.fifo_ren) begin
                check("ren_stall", 32'(bus.m_valid && !bus.m_ready), 32'd0);
                check("ren_empty", 32'(bus.fifo_empty), 32'd0);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (sb.size() == 0) check("extra_beat", 32'd1, 32'd0);
                else begin
                    mb = sb.pop_front();
                    check("data", 32'(bus.m_data), 32'(mb.d));
                    check("last", 32'(bus.m_last), 32'(mb.l));
                end
            end
        end
        prev_stall = !rst && bus.m_valid && !bus.m_ready;
        prev_out = {bus.m_last, bus.m_data};
    end
    initial begin
        int n;
        logic [3:0] idx;
        tick();
        tick();
        check("rst_valid", 32'(bus.m_valid), 32'd0);
        check("rst_data", 32'(bus.m_data), 32'd0);
        check("rst_last", 32'(bus.m_last), 32'd0);
        check("rst_ren", 32'(bus.fifo_ren), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_ren", 32'(bus.fifo_ren), 32'd0);
            check("idle_valid", 32'(bus.m_valid), 32'd0);
        end
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("lat_n_ren", 32'(bus.fifo_ren), 32'd0);
        check("lat_n_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("lat_n1_ren", 32'(bus.fifo_ren), 32'd1);
        check("lat_n1_valid", 32'(bus.m_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(bus.m_valid), 32'd1);
        drain(1'b0);
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) wr(8'hB0 + 8'(i));
        drain(1'b1);
        for (int i = 0; i < 16; i++) push(8'(i), i % 4 == 3);
        for (int i = 0; i < 16; i++) wr(8'(i));
        drain(1'b0);
        check("full_empty", 32'(bus.fifo_empty), 32'd1);
`ifdef FLUSH_TIMEOUT_EN
        push(8'h55, 1'b0);
        push(8'h66, 1'b1);
        wr(8'h55);
        wr(8'h66);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_early", 32'(bus.fifo_ren), 32'd0);
        end
        tick();
        check("flush_start", 32'(bus.fifo_ren), 32'd1);
        drain(1'b0);
`else
        wr(8'h55);
        wr(8'h66);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("resid_valid", 32'(bus.m_valid), 32'd0);
        end
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        push(8'h77, 1'b0);
        push(8'h88, 1'b1);
        wr(8'h77);
        wr(8'h88);
        drain(1'b0);
`endif
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), i == 3);
        for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
        n = 0;
        while (sb.size() > 2 && n < 100) begin
            tick();
            n++;
        end
        check("mid_timeout", 32'(sb.size()), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_last", 32'(bus.m_last), 32'd0);
        check("mid_rst_ren", 32'(bus.fifo_ren), 32'd0);
        sb.delete();
        tick();
        check("mid_rst_ren2", 32'(bus.fifo_ren), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
        check("post_rst_valid", 32'(bus.m_valid), 32'd0);
        n = int'(cnt);
        for (int i = 0; i < n; i++) begin
            idx = rp + 4'(i);
            push(mem[idx], i == 3);
        end
        for (int i = n; i < 4; i++) push(8'hD0 + 8'(i), i == 3);
        for (int i = n; i < 4; i++) wr(8'hD0 + 8'(i));
        drain(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for the 8-bit, 16-entry `fifo` block. It watches the FIFO's occupancy and drains it in fixed-length bursts onto a valid/ready stream with a last-beat marker. It never reads an empty FIFO, so the FIFO's read-while-empty skip path is never exercised. It sits between the `fifo` read port and a downstream packet consumer.

## Interface
Parameters:
- `MAX_DATA`, 16, FIFO depth; must match the attached `fifo`.
- `BURST_LEN`, 4, beats per full burst; legal range 1..`MAX_DATA`.
- `TIMEOUT`, 8, idle cycles before a short flush burst (used only with `FLUSH_TIMEOUT_EN`); must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `fifo_count` input 5: FIFO occupancy, 0..`MAX_DATA`.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rdata` input 8: FIFO head data; combinational, valid in the same cycle as the read.
- `fifo_ren` output 1: FIFO read enable; combinational.
- `m_valid` output 1: output beat valid.
- `m_ready` input 1: downstream accept.
- `m_data` output 8: output beat data.
- `m_last` output 1: marks the final beat of a burst.

## Operation
- States:
  - IDLE: no burst in progress.
  - FETCH: `beats_left` > 0.
  - DRAIN: all beats read; waiting for the final beat to be accepted.
- IDLE → FETCH when `fifo_count` ≥ `BURST_LEN`. On entry, load `beats_left` = `BURST_LEN`.
- `fifo_ren` = FETCH && `beats_left` != 0 && !`fifo_empty` && (!`m_valid` || `m_ready`).
  - `fifo_ren` is never asserted in IDLE or DRAIN.
  - `fifo_ren` is never asserted while `fifo_empty` = 1.
- On a cycle with `fifo_ren` = 1:
  - `m_data` ← `fifo_rdata`; `m_valid` ← 1; `beats_left` ← `beats_left` − 1.
  - `m_last` ← (`beats_left` == 1).
  - If `beats_left` == 1, FETCH → DRAIN.
- Handshake:
  - A beat transfers when `m_valid` && `m_ready`.
  - While `m_valid` && !`m_ready`: `m_data`, `m_last` and `m_valid` hold stable and no read occurs.
  - On a transfer with no simultaneous read, `m_valid` ← 0.
- DRAIN → IDLE on transfer of the beat with `m_last` = 1.
  - In the same cycle, IDLE evaluation starts the next cycle; there is no back-to-back burst chaining inside one cycle.
- Widths:
  - `beats_left` is 5 bits and saturates at 0.
  - `fifo_count` is compared unsigned against `BURST_LEN`, zero-extended to 5 bits.

## Timing
- Reset values: state IDLE, `m_valid` 0, `m_data` 8'h00, `m_last` 0, `beats_left` 0, wait timer 0; `fifo_ren` = 0.
- Reset is asynchronous and can occur mid-burst.
  - The burst is abandoned and the output beat is discarded.
  - Beats already read are lost; no FIFO read occurs while `rst` = 1.
- Latency:
  - `fifo_count` reaches `BURST_LEN` at cycle N → FETCH at N+1 → `fifo_ren` at N+1 → `m_valid` at N+2.
  - With `m_ready` held at 1, throughput is 1 beat/cycle. A `BURST_LEN` burst occupies `BURST_LEN` + 1 cycles from the first `fifo_ren` to the last accept.
- Simultaneous events: transfer and read in the same cycle replace the output register with no bubble.
- Boundary: `fifo_count` = `MAX_DATA` (full) behaves exactly like `fifo_count` ≥ `BURST_LEN`.
- Boundary: `BURST_LEN` = 1 makes every beat carry `m_last` = 1 and goes FETCH → DRAIN after a single read.

## Configuration
- `FLUSH_TIMEOUT_EN` defined:
  - In IDLE with !`fifo_empty` and `fifo_count` < `BURST_LEN`, a wait timer increments each cycle.
  - The timer clears when `fifo_empty` = 1 or when IDLE is left.
  - When the timer reaches `TIMEOUT` − 1, go to FETCH with `beats_left` = `fifo_count` (a short burst); `m_last` is set on that burst's final beat.
  - A full-burst condition in the same cycle takes priority and loads `BURST_LEN`.
- `FLUSH_TIMEOUT_EN` undefined:
  - The timer and `TIMEOUT` logic are absent.
  - Residual data below `BURST_LEN` stays in the FIFO indefinitely.

## Structure
- Shared package `fifo_pkg`:
  - `FIFO_DW` = 8, `FIFO_CW` = 5, default `MAX_DATA` = 16.
  - State enum `burst_state_t` {IDLE, FETCH, DRAIN}.
- One sub-module, `burst_timer`:
  - Holds the loadable down-counter (`beats_left`) and, under `FLUSH_TIMEOUT_EN`, the wait timer.
  - Exposes `done` and `timeout` strobes.
- The top level holds the FSM and the output register.

## Test plan
- Reset release with an empty FIFO, 20 cycles → `fifo_ren` = 0 and `m_valid` = 0 throughout.
- Write 4 bytes 0xA0..0xA3, `BURST_LEN` = 4, `m_ready` = 1:
  - 4 consecutive beats A0, A1, A2, A3 appear, with `m_last` only on A3.
  - `fifo_count` returns to 0 and the FSM returns to IDLE.
- Same stimulus with `m_ready` toggled 1,0,0,1,…:
  - `m_data` is held stable while stalled and the order is preserved.
  - No `fifo_ren` while `m_valid` && !`m_ready`.
- Fill the FIFO to 16 bytes 0x00..0x0F → 4 bursts, each with `m_last` on 0x03, 0x07, 0x0B and 0x0F; `fifo_empty` = 1 at the end.
- Write 2 bytes (0x55, 0x66) only:
  - Without `FLUSH_TIMEOUT_EN`: no output for 50 cycles.
  - With `FLUSH_TIMEOUT_EN` and `TIMEOUT` = 8: a 2-beat burst 0x55, 0x66 (`m_last` on 0x66) starts 8 cycles after the first write is visible.
- Assert `rst` after the 2nd beat of a 4-beat burst → `m_valid`, `m_last` and `fifo_ren` go to 0 immediately, and the state is IDLE after release.
